// File: rtl/bin_mgr_pkg.sv
// -----------------------------------------------------------------------------
// bin_mgr_pkg
// Shared types and constants for the bin-manager BRAM port-A arbiter.
//   arb_state_t : arbiter FSM state encoding
//   REQ_*       : fixed requester slot assignments
//   BURST_CNT_W : width of the burst-beat counter (MAX_BURST <= 255)
// -----------------------------------------------------------------------------
package bin_mgr_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int REQ_LOADER  = 0;
    localparam int REQ_SAVER   = 1;
    localparam int REQ_FETCH   = 2;

    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Selects the first asserted
// request at or above i_ptr, wrapping from N-1 back to 0.
// Ports:
//   i_req  [N-1:0]  request vector
//   i_ptr  [IW-1:0] highest-priority slot (must be < N)
//   o_gnt  [N-1:0]  one-hot winner (all zero when no request)
//   o_idx  [IW-1:0] index of the winner
//   o_any           at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [N-1:0] w_rot;
    logic [IW:0]  w_off;
    logic [IW:0]  w_sum;

    always_comb begin
        // Rotate so the pointer slot sits at bit 0; the lowest set bit of
        // the rotated vector is the winner's offset from the pointer.
        w_rot = N'({i_req, i_req} >> i_ptr);
        w_off = '0;
        o_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (IW + 1)'(j);
                o_any = 1'b1;
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (IW + 1)'(N)) begin
            w_sum = w_sum - (IW + 1)'(N);
        end
        o_idx = w_sum[IW-1:0];
        o_gnt = '0;
        for (int k = 0; k < N; k++) begin
            o_gnt[k] = o_any && (w_sum == (IW + 1)'(k));
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares port A of the bin-manager dual-port BRAM among NUM_REQ requesters
// with round-robin arbitration and optional burst locking. Read data comes
// back one cycle after the grant, tagged by a one-hot rvalid.
//
// State table:
//   ARB    | round-robin among all requesters starting at rr_ptr
//   LOCKED | only the burst owner may be granted, up to MAX_BURST beats
//
// Ports:
//   clk, rst_n           clock / synchronous active-low reset
//   req, lock, we        per-requester request, burst lock, write(1)/read(0)
//   addr, wdata          packed per-requester address / write data
//   gnt                  one-hot grant, access happens in the same cycle
//   rvalid, rdata        one-hot read-valid and shared read data bus
//   bram_we/addr/din     to BRAM port A; bram_dout from BRAM port A
//   stat_clr, stat_conflict
//                        present only with BRAM_ARB_STATS_EN defined:
//                        saturating count of cycles where some request
//                        was left waiting
// -----------------------------------------------------------------------------
module bram_port_arbiter
    import bin_mgr_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_din,
    input  logic [DATA_WIDTH-1:0]         bram_dout
`ifdef BRAM_ARB_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [15:0]                   stat_conflict
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

    arb_state_t               r_state, w_state_nxt;
    logic [IW-1:0]            r_rr_ptr, w_rr_ptr_nxt;
    logic [IW-1:0]            r_owner, w_owner_nxt;
    logic [BURST_CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
    logic [NUM_REQ-1:0]       r_rvalid;
    logic [DATA_WIDTH-1:0]    r_rdata_hold;

    logic [NUM_REQ-1:0]       w_pick_gnt;
    logic [IW-1:0]            w_pick_idx;
    logic                     w_pick_any;
    logic                     w_pick_lock;
    logic [NUM_REQ-1:0]       w_own_oh;
    logic                     w_own_req;
    logic                     w_own_lock;
    logic [NUM_REQ-1:0]       w_gnt;
    logic [NUM_REQ-1:0]       w_rvalid;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_comb begin
        w_own_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_own_oh[k] = (r_owner == IW'(k));
        end
    end

    assign w_own_req   = |(req & w_own_oh);
    assign w_own_lock  = |(lock & w_own_oh);
    assign w_pick_lock = |(lock & w_pick_gnt);

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_gnt           = '0;
        case (r_state)
            ARB: begin
                if (w_pick_any) begin
                    w_gnt        = w_pick_gnt;
                    w_rr_ptr_nxt = (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : w_pick_idx + IW'(1);
                    if (w_pick_lock && (MAX_BURST > 1)) begin
                        w_state_nxt     = LOCKED;
                        w_owner_nxt     = w_pick_idx;
                        w_burst_cnt_nxt = BURST_CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (w_own_req) begin
                    w_gnt = w_own_oh;
                    if (w_own_lock && (r_burst_cnt < BURST_LAST)) begin
                        w_burst_cnt_nxt = r_burst_cnt + BURST_CNT_W'(1);
                    end else begin
                        w_state_nxt     = ARB;
                        w_burst_cnt_nxt = '0;
                    end
                end else begin
                    // Owner went away: give up the lock without spending a beat.
                    w_state_nxt     = ARB;
                    w_burst_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
        // No access may reach the BRAM while reset is asserted.
        if (!rst_n) begin
            w_gnt = '0;
        end
    end

    always_comb begin
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                bram_we   = we[k];
                bram_addr = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                bram_din  = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ARB;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_burst_cnt  <= '0;
            r_rvalid     <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_rvalid    <= w_gnt & ~we;
            if (|r_rvalid) begin
                r_rdata_hold <= bram_dout;
            end
        end
    end

    // BRAM douta is already registered, so the data bus is taken straight
    // from it during the valid cycle and held from a shadow register after.
    // Masking with rst_n drops a read that was in flight when reset arrived.
    assign w_rvalid = rst_n ? r_rvalid : '0;
    assign rvalid   = w_rvalid;
    assign rdata    = (|w_rvalid) ? bram_dout : r_rdata_hold;
    assign gnt      = w_gnt;

`ifdef BRAM_ARB_STATS_EN
    logic [15:0] r_stat_conflict;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            r_stat_conflict <= '0;
        end else if ((|(req & ~w_gnt)) && (r_stat_conflict != 16'hFFFF)) begin
            r_stat_conflict <= r_stat_conflict + 16'd1;
        end
    end

    assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;
    import bin_mgr_pkg::*;

    localparam int NR = 3;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NR-1:0]    req, lock, we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]    gnt, rvalid;
    logic [DW-1:0]    rdata;
    logic             bram_we;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_din, bram_dout;
`ifdef BRAM_ARB_STATS_EN
    logic             stat_clr;
    logic [15:0]      stat_conflict;
`endif

    bram_port_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
`ifdef BRAM_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_conflict (stat_conflict)
`endif
    );

    // BRAM port A model: preloaded with addr+0x100, 1-cycle registered read.
    logic [DW-1:0] mem [0:1023];
    logic [1023:0] written = '0;
    always @(posedge clk) begin
        bram_dout <= written[bram_addr] ? mem[bram_addr] : DW'(bram_addr) + 16'h0100;
        if (bram_we) begin
            mem[bram_addr]     <= bram_din;
            written[bram_addr] <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] pre(input int a);
        return DW'(a + 256);
    endfunction

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [NR-1:0] v;
        logic [DW-1:0] d;
        int            c;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid !== '0) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL rvalid_unexpected: got %b expected none (cycle %0d)", rvalid, cyc);
            end else begin
                e = q.pop_front();
                check("rvalid_tag", 32'(rvalid), 32'(e.v));
                check("rdata", 32'(rdata), 32'(e.d));
                check("rvalid_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic r, input logic l, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]             = r;
        lock[i]            = l;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic exp_gnt(input string name, input logic [NR-1:0] e, input logic rd,
                           input logic [DW-1:0] d);
        exp_t x;
        #2;
        check(name, 32'(gnt), 32'(e));
        if (rd && (e != '0)) begin
            x.v = e;
            x.d = d;
            x.c = cyc + 1;
            q.push_back(x);
        end
    endtask

    task automatic all_off();
        req  = '0;
        lock = '0;
        we   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [NR-1:0] rr_seq [6];
    logic [NR-1:0] bl_seq [5];

    initial begin
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bl_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        rst_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
`ifdef BRAM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        tick(); tick();
        req = '1;
        #2;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_bram_we", 32'(bram_we), 0);
        tick();
        rst_n = 1'b1;
        all_off();

        // Reset while a read is in flight.
        tick();
        set_rq(REQ_LOADER, 1, 0, 0, 10'd3, 0);
        exp_gnt("midrd_gnt", 3'b001, 0, 0);
        tick();
        rst_n = 1'b0;
        #2;
        check("midrd_rst_gnt", 32'(gnt), 0);
        check("midrd_rvalid", 32'(rvalid), 0);
        tick();
        rst_n = 1'b1;
        all_off();
        #2;
        check("midrd_post_rvalid", 32'(rvalid), 0);

        // Round robin, all requesters reading; pointer must be back at 0.
        tick();
        set_rq(REQ_LOADER, 1, 0, 0, 10'd10, 0);
        set_rq(REQ_SAVER,  1, 0, 0, 10'd20, 0);
        set_rq(REQ_FETCH,  1, 0, 0, 10'd30, 0);
        for (int i = 0; i < 6; i++) begin
            exp_gnt("rr_gnt", rr_seq[i], 1, pre(10 * ((i % 3) + 1)));
            tick();
        end
        all_off();
        exp_gnt("idle_gnt", 3'b000, 0, 0);
        check("idle_bram_we", 32'(bram_we), 0);
        check("idle_bram_addr", 32'(bram_addr), 0);
        check("idle_bram_din", 32'(bram_din), 0);
        tick();
        #2;
        check("rdata_hold", 32'(rdata), 32'h011E);

        // Write then read the same address in the next cycle.
        tick();
        set_rq(REQ_LOADER, 1, 0, 1, 10'd5, 16'hBEEF);
        exp_gnt("wr_gnt", 3'b001, 0, 0);
        check("wr_bram_we", 32'(bram_we), 1);
        check("wr_bram_addr", 32'(bram_addr), 5);
        check("wr_bram_din", 32'(bram_din), 32'hBEEF);
        tick();
        set_rq(REQ_LOADER, 0, 0, 0, 0, 0);
        set_rq(REQ_SAVER,  1, 0, 0, 10'd5, 0);
        exp_gnt("fwd_gnt", 3'b010, 1, 16'hBEEF);
        tick();
        all_off();

        // Burst lock on requester 1, others contending (pointer ends up at 1).
        set_rq(REQ_FETCH, 1, 0, 0, 10'd30, 0);
        exp_gnt("bl_pre2", 3'b100, 1, pre(30));
        tick();
        set_rq(REQ_FETCH,  0, 0, 0, 10'd30, 0);
        set_rq(REQ_LOADER, 1, 0, 0, 10'd10, 0);
        exp_gnt("bl_pre0", 3'b001, 1, pre(10));
        tick();
        set_rq(REQ_SAVER, 1, 1, 0, 10'd20, 0);
        set_rq(REQ_FETCH, 1, 0, 0, 10'd30, 0);
        for (int i = 0; i < 5; i++) begin
            exp_gnt("burst_gnt", bl_seq[i], 1, (i < 4) ? pre(20) : pre(30));
            tick();
        end
        all_off();
        tick();

        // Lock released after the second beat.
        set_rq(REQ_LOADER, 1, 0, 0, 10'd10, 0);
        exp_gnt("er_pre0", 3'b001, 1, pre(10));
        tick();
        set_rq(REQ_SAVER, 1, 1, 0, 10'd20, 0);
        set_rq(REQ_FETCH, 1, 0, 0, 10'd30, 0);
        exp_gnt("er_beat1", 3'b010, 1, pre(20));
        tick();
        lock[REQ_SAVER] = 1'b0;
        exp_gnt("er_beat2", 3'b010, 1, pre(20));
        tick();
        exp_gnt("er_next", 3'b100, 1, pre(30));
        tick();
        all_off();
        tick();

        // Owner drops its request while locked.
        set_rq(REQ_LOADER, 1, 0, 0, 10'd10, 0);
        exp_gnt("od_pre0", 3'b001, 1, pre(10));
        tick();
        set_rq(REQ_SAVER, 1, 1, 0, 10'd20, 0);
        set_rq(REQ_FETCH, 1, 0, 0, 10'd30, 0);
        exp_gnt("od_lock", 3'b010, 1, pre(20));
        tick();
        set_rq(REQ_SAVER, 0, 0, 0, 10'd20, 0);
        exp_gnt("od_idle", 3'b000, 0, 0);
        tick();
        exp_gnt("od_next2", 3'b100, 1, pre(30));
        tick();
        exp_gnt("od_next0", 3'b001, 1, pre(10));
        tick();
        all_off();

`ifdef BRAM_ARB_STATS_EN
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int i = 0; i < NR; i++) set_rq(i, 1, 0, 1, AW'(100 + i), 16'h5A5A);
        #2;
        check("stat_cleared", 32'(stat_conflict), 0);
        repeat (9) tick();
        tick();
        all_off();
        #2;
        check("stat_ten", 32'(stat_conflict), 10);
        tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #2;
        check("stat_clr", 32'(stat_conflict), 0);
        for (int i = 0; i < NR; i++) set_rq(i, 1, 0, 1, AW'(100 + i), 16'h5A5A);
        repeat (65540) tick();
        all_off();
        #2;
        check("stat_sat", 32'(stat_conflict), 32'hFFFF);
`endif

        tick(); tick(); tick();
        check("sb_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
